// File: rtl/serial_frame_pkg.sv
// Shared constants and phase decode for the serial test-interface frame controller.
// The 40-cycle frame is split into load, start, write, read and end windows.
package serial_frame_pkg;

    localparam int FRAME_LEN = 40;
    localparam int CMD_W     = 8;
    localparam int RD_BITS   = 9;

    localparam logic [5:0] CNT_LOAD     = 6'd0;
    localparam logic [5:0] CNT_START    = 6'd1;
    localparam logic [5:0] CNT_WR_FIRST = 6'd2;
    localparam logic [5:0] CNT_WR_LAST  = 6'd17;
    localparam logic [5:0] CNT_RD_FIRST = 6'd18;
    localparam logic [5:0] CNT_RD_LAST  = 6'd35;
    localparam logic [5:0] CNT_RSP      = 6'd36;
    localparam logic [5:0] CNT_ARB      = 6'(FRAME_LEN - 1);

    typedef enum logic [2:0] {LOAD, START, WRITE, READ, END} phase_t;

    function automatic phase_t phase_of(input logic [5:0] cnt);
        if (cnt == CNT_LOAD)
            return LOAD;
        else if (cnt == CNT_START)
            return START;
        else if (cnt >= CNT_WR_FIRST && cnt <= CNT_WR_LAST)
            return WRITE;
        else if (cnt >= CNT_RD_FIRST && cnt <= CNT_RD_LAST)
            return READ;
        else
            return END;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from (ptr + 1) mod NREQ and grants the first
// requester found, only when advance is high. Purely combinational.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam int SW = IDX_W + 1;

    logic [IDX_W-1:0] cand_idx [NREQ];
    logic [NREQ-1:0]  cand_req;

    // Candidate gi is the requester gi+1 places after the pointer, wrapped once.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [SW-1:0] sum;
        assign sum = {1'b0, ptr} + SW'(gi + 1);
        assign cand_idx[gi] = (sum >= SW'(NREQ)) ? IDX_W'(sum - SW'(NREQ)) : sum[IDX_W-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && cand_req[k]) begin
                valid = 1'b1;
                idx   = cand_idx[k];
            end
        end
        valid = valid & advance;
        if (valid)
            gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Frame controller: 40-cycle frame counter, round-robin grant at count 39, serial
// command write, 9-bit read-back capture and a one-cycle response strobe at count 36.
module serial_frame_scheduler #(
    parameter int NREQ  = 4,
    parameter int CMD_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CMD_W-1:0] cmd,
    output logic [NREQ-1:0]       gnt,
    output logic [5:0]            count40,
    output logic                  frame_active,
    output logic                  dq_out,
    output logic                  dq_oe,
    input  logic                  dq_in,
    output logic                  rsp_valid,
    output logic [2:0]            rsp_id,
    output logic                  rsp_ack,
    output logic [7:0]            rsp_data
);

    import serial_frame_pkg::*;

    localparam int IDX_W = $clog2(NREQ);

    logic [5:0]         count_reg;
    logic [NREQ-1:0]    gnt_reg;
    logic               frame_active_reg;
    logic               dq_out_reg;
    logic               dq_oe_reg;
    logic               rsp_valid_reg;
    logic [2:0]         rsp_id_reg;
    logic               rsp_ack_reg;
    logic [7:0]         rsp_data_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   gnt_idx_reg;
    logic [CMD_W-1:0]   tx_shift_reg;
    logic [RD_BITS-2:0] rx_shift_reg;

    logic [5:0]       count_next;
    logic             frame_active_next;
    logic             arb_advance;
    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [CMD_W-1:0] cmd_sel;
    phase_t           phase_now;
    phase_t           phase_next;
    logic             write_next;

    // Out-of-range counts are unreachable but still fold back to 0.
    assign count_next  = (count_reg >= CNT_ARB) ? CNT_LOAD : count_reg + 6'd1;
    assign arb_advance = (count_reg == CNT_ARB);
    assign phase_now   = phase_of(count_reg);
    assign phase_next  = phase_of(count_next);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .advance (arb_advance),
        .ptr     (ptr_reg),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .valid   (arb_valid)
    );

    assign cmd_sel           = cmd[arb_idx*CMD_W +: CMD_W];
    assign frame_active_next = arb_advance ? arb_valid : frame_active_reg;
    assign write_next        = frame_active_next && (phase_next == WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg        <= CNT_LOAD;
            gnt_reg          <= '0;
            frame_active_reg <= 1'b0;
            dq_out_reg       <= 1'b0;
            dq_oe_reg        <= 1'b0;
            rsp_valid_reg    <= 1'b0;
            rsp_id_reg       <= '0;
            rsp_ack_reg      <= 1'b0;
            rsp_data_reg     <= '0;
            ptr_reg          <= IDX_W'(NREQ - 1);
            gnt_idx_reg      <= '0;
            tx_shift_reg     <= '0;
            rx_shift_reg     <= '0;
        end else begin
            count_reg        <= count_next;
            gnt_reg          <= arb_gnt;
            frame_active_reg <= frame_active_next;

            if (arb_valid) begin
                ptr_reg      <= arb_idx;
                gnt_idx_reg  <= arb_idx;
                tx_shift_reg <= cmd_sel;
            end else if (write_next && count_next[0]) begin
                // Each bit is shown for an even/odd count pair; advance after the odd one.
                tx_shift_reg <= tx_shift_reg << 1;
            end

            dq_oe_reg  <= write_next;
            dq_out_reg <= write_next ? tx_shift_reg[CMD_W-1] : 1'b0;

            // Read-back bits are sampled on the edge leaving each odd READ count.
            if (phase_now == READ && count_reg[0])
                rx_shift_reg <= {rx_shift_reg[RD_BITS-3:0], dq_in};

            rsp_valid_reg <= 1'b0;
            if (frame_active_reg && count_next == CNT_RSP) begin
                rsp_valid_reg <= 1'b1;
                rsp_id_reg    <= 3'(gnt_idx_reg);
                rsp_ack_reg   <= rx_shift_reg[RD_BITS-2];
                rsp_data_reg  <= {rx_shift_reg[RD_BITS-3:0], dq_in};
            end
        end
    end

    assign count40      = count_reg;
    assign gnt          = gnt_reg;
    assign frame_active = frame_active_reg;
    assign dq_out       = dq_out_reg;
    assign dq_oe        = dq_oe_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_ack      = rsp_ack_reg;
    assign rsp_data     = rsp_data_reg;

endmodule
